// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: reads one or two words at PC, splits the opcode and
// operand fields, and offers the decoded instruction to execute via valid/ready.
module instr_fetch_decode #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int PC_INIT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [3:0]            oc,
    output logic [3:0]            op_a,
    output logic [3:0]            op_b,
    output logic [3:0]            op_c,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  two_word,
    output logic                  illegal,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted
);

    localparam logic [3:0] OC_MOV  = 4'b0000;
    localparam logic [3:0] OC_ADD  = 4'b0001;
    localparam logic [3:0] OC_SUB  = 4'b0010;
    localparam logic [3:0] OC_MUL  = 4'b0011;
    localparam logic [3:0] OC_DIV  = 4'b0100;
    localparam logic [3:0] OC_IN   = 4'b0111;
    localparam logic [3:0] OC_OUT  = 4'b1000;
    localparam logic [3:0] OC_STOP = 4'b1111;
    localparam logic [3:0] C_CONST = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH1,
        S_WAIT1,
        S_FETCH2,
        S_WAIT2,
        S_VALID,
        S_HALT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0] w_oc;
    logic [3:0] w_a;
    logic [3:0] w_b;
    logic [3:0] w_c;
    logic       dec_legal;
    logic       dec_two;
    logic       retire_stop;
    logic       accept;

    // Field view of the first instruction word as it returns from memory.
    assign w_oc = mem_rdata[15:12];
    assign w_a  = mem_rdata[11:8];
    assign w_b  = mem_rdata[7:4];
    assign w_c  = mem_rdata[3:0];

    // Opcode legality and instruction length from the word being returned.
    always_comb begin
        dec_legal = 1'b0;
        case (w_oc)
            OC_MOV,
            OC_ADD,
            OC_SUB,
            OC_MUL,
            OC_DIV,
            OC_IN,
            OC_OUT,
            OC_STOP: dec_legal = 1'b1;
            default: dec_legal = 1'b0;
        endcase
        dec_two = (w_oc == OC_MOV) && (w_c == C_CONST);
    end

    assign accept      = (state == S_VALID) && instr_ready;
    assign retire_stop = (oc == OC_STOP) || illegal;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; HALT is only left through reset.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH1;
                end
            end
            S_FETCH1: state_nxt = S_WAIT1;
            S_WAIT1: begin
                if (dec_two) begin
                    state_nxt = S_FETCH2;
                end else begin
                    state_nxt = S_VALID;
                end
            end
            S_FETCH2: state_nxt = S_WAIT2;
            S_WAIT2:  state_nxt = S_VALID;
            S_VALID: begin
                if (instr_ready) begin
                    if (retire_stop) begin
                        state_nxt = S_HALT;
                    end else begin
                        state_nxt = S_FETCH1;
                    end
                end
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus request and status flags decoded straight from the state.
    always_comb begin
        mem_req     = (state == S_FETCH1) || (state == S_FETCH2);
        mem_addr    = mem_req ? pc : '0;
        instr_valid = (state == S_VALID);
        halted      = (state == S_HALT);
    end

    // PC steps once per issued read and wraps at the top of memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= ADDR_WIDTH'(PC_INIT);
        end else if (mem_req) begin
            pc <= pc + ADDR_WIDTH'(1);
        end
    end

    // Opcode and operand fields are captured once and held until the next fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oc       <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_c     <= '0;
            two_word <= 1'b0;
            illegal  <= 1'b0;
        end else if (state == S_WAIT1) begin
            oc       <= w_oc;
            op_a     <= w_a;
            op_b     <= w_b;
            op_c     <= w_c;
            two_word <= dec_two;
            illegal  <= !dec_legal;
        end
    end

    // Constant word; cleared for one-word instructions so no stale value leaks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm <= '0;
        end else if (state == S_WAIT1) begin
            imm <= '0;
        end else if (state == S_WAIT2) begin
            imm <= mem_rdata;
        end
    end

    // Handshake bookkeeping is purely combinational; keep the term referenced.
    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Testbench for instr_fetch_decode: directed vector table, hand sequences
// for stall/wrap/halt/reset, and random programs against a memory-walk model.
module tb_instr_fetch_decode;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mem_req;
    logic [5:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  oc, op_a, op_b, op_c;
    logic [15:0] imm;
    logic        two_word, illegal, halted;
    logic [5:0]  pc;

    logic        start2;
    logic        mem_req2;
    logic [5:0]  mem_addr2;
    logic [15:0] mem_rdata2;
    logic        instr_valid2;
    logic        instr_ready2;
    logic [3:0]  oc2, op_a2, op_b2, op_c2;
    logic [15:0] imm2;
    logic        two_word2, illegal2, halted2;
    logic [5:0]  pc2;

    logic [15:0] mem  [64];
    logic [15:0] mem2 [64];

    int total = 0;
    int bad   = 0;

    instr_fetch_decode #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .PC_INIT(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .oc(oc), .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .imm(imm), .two_word(two_word), .illegal(illegal),
        .pc(pc), .halted(halted)
    );

    instr_fetch_decode #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .PC_INIT(63)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready2),
        .oc(oc2), .op_a(op_a2), .op_b(op_b2), .op_c(op_c2),
        .imm(imm2), .two_word(two_word2), .illegal(illegal2),
        .pc(pc2), .halted(halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories: data the cycle after the request.
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= mem[mem_addr];
        if (mem_req2) mem_rdata2 <= mem2[mem_addr2];
    end

    typedef struct {
        logic [15:0] w1;
        logic [15:0] w2;
        logic [3:0]  oc, a, b, c;
        logic [15:0] imm;
        logic        two;
        logic        ill;
        logic        hlt;
        logic [5:0]  npc;
        int          lat;
    } vec_t;

    typedef struct {
        logic [3:0]  oc, a, b, c;
        logic [15:0] imm;
        logic        two;
        logic        ill;
        logic        stop;
        logic [5:0]  npc;
    } ins_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: what the instruction at address p should decode to.
    function automatic ins_t decode_at(input logic [5:0] p);
        ins_t r;
        logic [15:0] w;
        logic [5:0] p1;
        w = mem[p];
        p1 = p + 6'd1;
        r.oc = w[15:12];
        r.a = w[11:8];
        r.b = w[7:4];
        r.c = w[3:0];
        r.two = (r.oc == 4'h0) && (r.c == 4'h8);
        r.imm = r.two ? mem[p1] : 16'h0;
        r.npc = r.two ? p + 6'd2 : p + 6'd1;
        r.ill = !(r.oc inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'hF});
        r.stop = (r.oc == 4'hF) || r.ill;
        return r;
    endfunction

    function automatic vec_t mkv(input logic [15:0] w1, input logic [15:0] w2,
                                 input logic [15:0] im, input logic two,
                                 input logic ill, input logic hlt,
                                 input logic [5:0] npc, input int lat);
        vec_t v;
        v.w1 = w1; v.w2 = w2;
        v.oc = w1[15:12]; v.a = w1[11:8]; v.b = w1[7:4]; v.c = w1[3:0];
        v.imm = im; v.two = two; v.ill = ill; v.hlt = hlt;
        v.npc = npc; v.lat = lat;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_random(input int nins);
        logic [5:0] p;
        logic [5:0] mpc;
        logic [5:0] nxt;
        logic [15:0] w;
        logic [3:0] op;
        ins_t e;
        int since;
        bit first;
        bit expect_halt;
        bit done;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        p = 6'd8;
        for (int k = 0; k < nins; k++) begin
            case ($urandom_range(0, 7))
                0: op = 4'h0;
                1: op = 4'h1;
                2: op = 4'h2;
                3: op = 4'h3;
                4: op = 4'h4;
                5: op = 4'h7;
                default: op = 4'h8;
            endcase
            w = {op, 12'($urandom)};
            if ($urandom_range(0, 3) == 0) w = {4'h0, 8'($urandom), 4'h8};
            mem[p] = w;
            p = p + 6'd1;
            if (w[15:12] == 4'h0 && w[3:0] == 4'h8) begin
                mem[p] = 16'($urandom);
                p = p + 6'd1;
            end
        end
        mem[p] = 16'hF000;
        do_reset();
        mpc = 6'd8;
        since = 0;
        first = 1'b1;
        expect_halt = 1'b0;
        done = 1'b0;
        instr_ready = 1'b0;
        start = 1'b1;
        for (int cyc = 0; cyc < 1500 && !done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            since++;
            if (expect_halt) begin
                chk("r_halted", halted, 1);
                chk("r_halt_pc", pc, mpc);
                chk("r_halt_req", mem_req, 0);
                done = 1'b1;
            end else begin
                e = decode_at(mpc);
                if (instr_valid) begin
                    if (first) begin
                        chk("r_latency", since, e.two ? 5 : 3);
                        first = 1'b0;
                    end
                    chk("r_fields", {oc, op_a, op_b, op_c}, {e.oc, e.a, e.b, e.c});
                    chk("r_imm", imm, e.imm);
                    chk("r_flags", {two_word, illegal}, {e.two, e.ill});
                    chk("r_pc", pc, e.npc);
                    chk("r_req_valid", mem_req, 0);
                    instr_ready = 1'($urandom_range(0, 1));
                    if (instr_ready) begin
                        mpc = e.npc;
                        since = 0;
                        first = 1'b1;
                        expect_halt = e.stop;
                    end
                end else begin
                    chk("r_req", mem_req, (since == 1) || (e.two && since == 3));
                    if (mem_req) begin
                        nxt = mpc + 6'd1;
                        chk("r_addr", mem_addr, (since == 1) ? mpc : nxt);
                    end
                    instr_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!done) chk("r_timeout", 0, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        instr_ready = 1'b0;
        instr_ready2 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 16'h0;
            mem2[i] = 16'h0;
        end

        vt[0]  = mkv(16'h1123, 16'h0000, 16'h0000, 0, 0, 0, 6'd9,  3);
        vt[1]  = mkv(16'h0518, 16'h00AB, 16'h00AB, 1, 0, 0, 6'd10, 5);
        vt[2]  = mkv(16'h5000, 16'h1111, 16'h0000, 0, 1, 1, 6'd9,  3);
        vt[3]  = mkv(16'hF000, 16'h2222, 16'h0000, 0, 0, 1, 6'd9,  3);
        vt[4]  = mkv(16'h0128, 16'hBEEF, 16'hBEEF, 1, 0, 0, 6'd10, 5);
        vt[5]  = mkv(16'h0129, 16'hBEEF, 16'h0000, 0, 0, 0, 6'd9,  3);
        vt[6]  = mkv(16'h3ABC, 16'h1234, 16'h0000, 0, 0, 0, 6'd9,  3);
        vt[7]  = mkv(16'h1128, 16'h4321, 16'h0000, 0, 0, 0, 6'd9,  3);
        vt[8]  = mkv(16'h7000, 16'h0000, 16'h0000, 0, 0, 0, 6'd9,  3);
        vt[9]  = mkv(16'h8FFF, 16'h0000, 16'h0000, 0, 0, 0, 6'd9,  3);
        vt[10] = mkv(16'h6000, 16'h0000, 16'h0000, 0, 1, 1, 6'd9,  3);
        vt[11] = mkv(16'h2F08, 16'h9999, 16'h0000, 0, 0, 0, 6'd9,  3);

        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 8);
        chk("rst_pc2", pc2, 63);
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fields", {oc, op_a, op_b, op_c, imm}, 0);
        chk("rst_flags", {two_word, illegal}, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_reset();
            mem[8] = vt[i].w1;
            mem[9] = vt[i].w2;
            instr_ready = 1'b1;
            pulse_start();
            chk($sformatf("v%0d_req1", i), mem_req, 1);
            chk($sformatf("v%0d_addr1", i), mem_addr, 8);
            wait_valid(n);
            chk($sformatf("v%0d_lat", i), n, vt[i].lat);
            chk($sformatf("v%0d_fields", i), {oc, op_a, op_b, op_c},
                {vt[i].oc, vt[i].a, vt[i].b, vt[i].c});
            chk($sformatf("v%0d_imm", i), imm, vt[i].imm);
            chk($sformatf("v%0d_two", i), two_word, vt[i].two);
            chk($sformatf("v%0d_ill", i), illegal, vt[i].ill);
            chk($sformatf("v%0d_pc", i), pc, vt[i].npc);
            @(negedge clk);
            chk($sformatf("v%0d_halt", i), halted, vt[i].hlt);
            chk($sformatf("v%0d_next_req", i), mem_req, !vt[i].hlt);
        end

        // Stall: outputs frozen, no bus use, then refetch right after accept.
        do_reset();
        mem[8] = 16'h1123;
        mem[9] = 16'h2456;
        instr_ready = 1'b0;
        pulse_start();
        wait_valid(n);
        chk("stall_lat", n, 3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_valid", instr_valid, 1);
            chk("stall_fields", {oc, op_a, op_b, op_c}, 16'h1123);
            chk("stall_imm", imm, 0);
            chk("stall_req", mem_req, 0);
            chk("stall_pc", pc, 9);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        chk("stall_refetch_req", mem_req, 1);
        chk("stall_refetch_addr", mem_addr, 9);
        chk("stall_refetch_valid", instr_valid, 0);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_valid", instr_valid, 1);
        chk("b2b_fields", {oc, op_a, op_b, op_c}, 16'h2456);

        // PC wrap: two-word instruction at 63 takes its constant from 0.
        do_reset();
        mem2[63] = 16'h0218;
        mem2[0] = 16'h1234;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("wrap_req1", mem_req2, 1);
        chk("wrap_addr1", mem_addr2, 63);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_req2", mem_req2, 1);
        chk("wrap_addr2", mem_addr2, 0);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_valid", instr_valid2, 1);
        chk("wrap_imm", imm2, 16'h1234);
        chk("wrap_two", two_word2, 1);
        chk("wrap_fields", {oc2, op_a2, op_b2, op_c2}, 16'h0218);
        chk("wrap_pc", pc2, 1);
        chk("wrap_ill_halt", {illegal2, halted2}, 0);

        // Halt: no further fetches and start is ignored.
        do_reset();
        mem[8] = 16'hF000;
        instr_ready = 1'b1;
        pulse_start();
        wait_valid(n);
        @(negedge clk);
        chk("halt_flag", halted, 1);
        repeat (2) begin
            @(negedge clk);
            chk("halt_req", mem_req, 0);
            chk("halt_valid", instr_valid, 0);
        end
        pulse_start();
        repeat (3) begin
            @(negedge clk);
            chk("halt_start_req", mem_req, 0);
            chk("halt_start_halted", halted, 1);
            chk("halt_start_pc", pc, 9);
        end

        // Reset during WAIT2 returns to IDLE immediately, then refetches at 8.
        do_reset();
        mem[8] = 16'h0518;
        mem[9] = 16'h00AB;
        instr_ready = 1'b1;
        pulse_start();
        repeat (3) @(negedge clk);
        chk("w2_req", mem_req, 0);
        chk("w2_pc", pc, 10);
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", pc, 8);
        chk("arst_valid", instr_valid, 0);
        chk("arst_req", mem_req, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_idle_req", mem_req, 0);
        chk("arst_idle_pc", pc, 8);
        pulse_start();
        chk("arst_refetch_addr", mem_addr, 8);
        wait_valid(n);
        chk("arst_refetch_lat", n, 5);
        chk("arst_refetch_imm", imm, 16'h00AB);

        // Start held across reset release is not taken.
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_start_req", mem_req, 0);
            chk("rst_start_pc", pc, 8);
        end

        for (int r = 0; r < 4; r++) begin
            run_random(14);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
